// File: rtl/icache_fetch_responder.sv
// -----------------------------------------------------------------------------
// icache_fetch_responder
//
// Responder end of the instruction-fetch sram-like bus. A line-aligned virtual
// index is accepted with inst_index_ok; the physical tag and cache attribute
// arrive one cycle later. A direct-mapped, blocking cache returns a full
// 128-bit line (4 instructions) on a hit, or a line read is issued on the
// refill bus on a miss or uncached access.
//
// Bus handshakes (one rule for both buses): a transfer happens on a rising
// clk edge where the requester's valid (inst_req / rd_req) and the
// responder's ready (inst_index_ok / rd_rdy) are both high. ret_valid and
// inst_data_ok are single-cycle pushes with no back-pressure.
//
// Ports:
//   clk, rst            clock; synchronous reset, active low
//   inst_req            fetch request
//   inst_wr, inst_size  write flag / size (always read, 4 words; ignored)
//   inst_index          virtual index, low OFF_W bits are zero
//   inst_wdata          unused write data
//   inst_index_ok       request accepted this cycle (combinational)
//   inst_ptag           physical tag, valid the cycle after the accept
//   inst_uncached       cache attribute, same timing as inst_ptag
//   inst_data_ok        line returned (one-cycle pulse)
//   inst_rdata          returned line, word k at [32k+31:32k]
//   flush_i             cancels the outstanding fetch
//   rd_req/rd_addr/rd_uncached/rd_rdy   refill read request channel
//   ret_valid/ret_last/ret_data         refill beats, word 0 first
// -----------------------------------------------------------------------------
module icache_fetch_responder #(
    parameter int INDEX_W = 8,
    parameter int TAG_W   = 20,
    parameter int OFF_W   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     inst_req,
    input  logic                     inst_wr,
    input  logic [1:0]               inst_size,
    input  logic [INDEX_W+OFF_W-1:0] inst_index,
    input  logic [31:0]              inst_wdata,
    output logic                     inst_index_ok,
    input  logic [TAG_W-1:0]         inst_ptag,
    input  logic                     inst_uncached,
    output logic                     inst_data_ok,
    output logic [127:0]             inst_rdata,
    input  logic                     flush_i,
    output logic                     rd_req,
    output logic [31:0]              rd_addr,
    output logic                     rd_uncached,
    input  logic                     rd_rdy,
    input  logic                     ret_valid,
    input  logic                     ret_last,
    input  logic [31:0]              ret_data
);

    localparam int LINES = 1 << INDEX_W;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_MISS   = 3'd2,
        S_REFILL = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    state_t state_q, state_d;

    // Cache arrays: tag and data are plain memories; valid bits are cleared on reset.
    logic [TAG_W-1:0]   tag_mem  [LINES];
    logic [127:0]       data_mem [LINES];
    logic [LINES-1:0]   valid_q;

    // Synchronous read results captured on the accept edge.
    logic [INDEX_W-1:0] idx_q;
    logic [TAG_W-1:0]   tag_rd_q;
    logic [127:0]       line_rd_q;
    logic               valid_rd_q;

    // Miss / refill bookkeeping.
    logic [31:0]        rd_addr_q;
    logic               unc_q;
    logic [1:0]         beat_q;
    logic [127:0]       lbuf_q;
    logic               cancel_q, cancel_d;
    logic [127:0]       rdata_q;

    logic [INDEX_W-1:0] req_idx;
    logic               hit;
    logic               lookup_hit;
    logic               miss_take;
    logic               accept;
    logic               resp_ok;
    logic               beat_fire;
    logic               install;
    logic [127:0]       line_wr;
    logic               unused_ok;

    assign unused_ok = ^{inst_wr, inst_size, inst_wdata, inst_index[OFF_W-1:0]};

    assign req_idx    = inst_index[OFF_W +: INDEX_W];
    assign hit        = valid_rd_q && (tag_rd_q == inst_ptag) && !inst_uncached;
    assign lookup_hit = (state_q == S_LOOKUP) && hit && !flush_i;
    assign miss_take  = (state_q == S_LOOKUP) && !hit && !flush_i;

    // Gated by rst so every output reads zero while reset is held.
    assign inst_index_ok = rst && ((state_q == S_IDLE) || lookup_hit);
    assign accept        = inst_req && inst_index_ok;

    assign resp_ok      = (state_q == S_RESP) && !cancel_q && !flush_i;
    assign inst_data_ok = rst && (lookup_hit || resp_ok);

    // Hit data comes straight from the array read; otherwise hold the last line.
    always_comb begin
        inst_rdata = rdata_q;
        if (inst_data_ok) begin
            inst_rdata = lookup_hit ? line_rd_q : lbuf_q;
        end
    end

    assign rd_req      = (state_q == S_MISS);
    assign rd_addr     = rd_addr_q;
    assign rd_uncached = unc_q;

    // The final beat is merged here so the installed line includes it.
    always_comb begin
        line_wr = lbuf_q;
        line_wr[{beat_q, 5'd0} +: 32] = ret_data;
    end

    assign beat_fire = (state_q == S_REFILL) && ret_valid;
    assign install   = rst && beat_fire && ret_last && !unc_q;

    always_comb begin
        state_d  = state_q;
        cancel_d = cancel_q;
        case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (flush_i)      state_d = S_IDLE;
                else if (hit)     state_d = accept ? S_LOOKUP : S_IDLE;
                else              state_d = S_MISS;
            end
            S_MISS: begin
                // Once the read is handed off it must be drained; a flush only marks it.
                if (rd_rdy) begin
                    state_d = S_REFILL;
                    if (flush_i) cancel_d = 1'b1;
                end else if (flush_i) begin
                    state_d = S_IDLE;
                end
            end
            S_REFILL: begin
                if (flush_i) cancel_d = 1'b1;
                if (beat_fire && ret_last) state_d = S_RESP;
            end
            S_RESP: begin
                cancel_d = 1'b0;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            valid_q    <= '0;
            idx_q      <= '0;
            tag_rd_q   <= '0;
            line_rd_q  <= '0;
            valid_rd_q <= 1'b0;
            rd_addr_q  <= '0;
            unc_q      <= 1'b0;
            beat_q     <= '0;
            lbuf_q     <= '0;
            cancel_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q  <= state_d;
            cancel_q <= cancel_d;
            if (accept) begin
                idx_q      <= req_idx;
                tag_rd_q   <= tag_mem[req_idx];
                line_rd_q  <= data_mem[req_idx];
                valid_rd_q <= valid_q[req_idx];
            end
            if (miss_take) begin
                rd_addr_q <= {inst_ptag, idx_q, {OFF_W{1'b0}}};
                unc_q     <= inst_uncached;
            end
            if ((state_q == S_MISS) && rd_rdy) begin
                beat_q <= '0;
            end
            if (beat_fire) begin
                lbuf_q <= line_wr;
                beat_q <= beat_q + 2'd1;
            end
            if (install) begin
                valid_q[idx_q] <= 1'b1;
            end
            if (inst_data_ok) begin
                rdata_q <= inst_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (install) begin
            tag_mem[idx_q]  <= rd_addr_q[OFF_W+INDEX_W +: TAG_W];
            data_mem[idx_q] <= line_wr;
        end
    end

`ifndef SYNTHESIS
    // A short or long burst is a bus protocol error; the line is still installed.
    a_last_beat_count: assert property (@(posedge clk) disable iff (!rst)
        (beat_fire && ret_last) |-> (beat_q == 2'd3));
`endif

endmodule

// File: tb/tb_icache_fetch_responder.sv
// -----------------------------------------------------------------------------
// Testbench for icache_fetch_responder: table of single fetches with expected
// refill behaviour, plus hand-written sequences for back-to-back hits, flush
// in LOOKUP / MISS / REFILL, and reset during a refill. A background refill
// responder serves rd_req with random delays; a negedge monitor compares every
// returned line against an expected queue.
// -----------------------------------------------------------------------------
module tb_icache_fetch_responder;

    logic         clk = 1'b0;
    logic         rst;
    logic         inst_req;
    logic         inst_wr;
    logic [1:0]   inst_size;
    logic [11:0]  inst_index;
    logic [31:0]  inst_wdata;
    logic         inst_index_ok;
    logic [19:0]  inst_ptag;
    logic         inst_uncached;
    logic         inst_data_ok;
    logic [127:0] inst_rdata;
    logic         flush_i;
    logic         rd_req;
    logic [31:0]  rd_addr;
    logic         rd_uncached;
    logic         rd_rdy;
    logic         ret_valid;
    logic         ret_last;
    logic [31:0]  ret_data;

    logic         tb_flush   = 1'b0;
    logic         resp_flush = 1'b0;
    assign flush_i = tb_flush | resp_flush;

    icache_fetch_responder dut (
        .clk          (clk),
        .rst          (rst),
        .inst_req     (inst_req),
        .inst_wr      (inst_wr),
        .inst_size    (inst_size),
        .inst_index   (inst_index),
        .inst_wdata   (inst_wdata),
        .inst_index_ok(inst_index_ok),
        .inst_ptag    (inst_ptag),
        .inst_uncached(inst_uncached),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .flush_i      (flush_i),
        .rd_req       (rd_req),
        .rd_addr      (rd_addr),
        .rd_uncached  (rd_uncached),
        .rd_rdy       (rd_rdy),
        .ret_valid    (ret_valid),
        .ret_last     (ret_last),
        .ret_data     (ret_data)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;
    logic [127:0] exp_q[$];
    logic [127:0] hold_exp = '0;
    int dok_cnt = 0;

    // responder state
    logic        rdy_block     = 1'b0;
    int          flush_at_beat = -1;
    int          ref_cnt       = 0;
    logic [31:0] last_addr     = '0;
    logic        last_unc      = 1'b0;
    int          last_beat_cyc = 0;
    logic        resp_busy     = 1'b0;
    int          beat_num      = -1;

    // Backing memory: the first test line uses 11,22,33,44; others are hashed.
    function automatic logic [31:0] mem_word(input logic [31:0] a, input int k);
        logic [31:0] kk;
        kk = 32'(k + 1);
        if (a == 32'hBFC00040) return 32'h11 * kk;
        return (a * 32'h9E3779B1) ^ (kk * 32'h01010101);
    endfunction

    // Uncached device space returns the inverse so a stray install is visible.
    function automatic logic [127:0] exp_line(input logic [31:0] a, input logic unc);
        logic [127:0] l;
        for (int k = 0; k < 4; k++) begin
            l[32*k +: 32] = unc ? ~mem_word(a, k) : mem_word(a, k);
        end
        return l;
    endfunction

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [127:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                hold_exp = '0;
            end else if (inst_data_ok) begin
                dok_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_data_ok: got data_ok=1 rdata=%h, required no response", inst_rdata);
                end else begin
                    e = exp_q.pop_front();
                    if (inst_rdata !== e) begin
                        errors++;
                        $display("FAIL rdata: got %h, required %h", inst_rdata, e);
                    end
                    hold_exp = e;
                end
            end else begin
                checks++;
                if (inst_rdata !== hold_exp) begin
                    errors++;
                    $display("FAIL rdata_hold: got %h, required %h", inst_rdata, hold_exp);
                end
            end
        end
    end

    // ---------------- refill responder ----------------
    initial begin
        logic [31:0] a;
        logic        u;
        rd_rdy = 1'b0; ret_valid = 1'b0; ret_last = 1'b0; ret_data = '0;
        forever begin
            @(posedge clk); #1;
            if (rd_req && !rdy_block) begin
                resp_busy = 1'b1;
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                if (rd_req) begin
                    a = rd_addr; u = rd_uncached;
                    ref_cnt++; last_addr = a; last_unc = u;
                    rd_rdy = 1'b1;
                    @(posedge clk); #1;
                    rd_rdy = 1'b0;
                    for (int k = 0; k < 4; k++) begin
                        repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
                        ret_valid  = 1'b1;
                        ret_last   = (k == 3);
                        ret_data   = u ? ~mem_word(a, k) : mem_word(a, k);
                        resp_flush = (k == flush_at_beat);
                        beat_num   = k;
                        last_beat_cyc = cyc;
                        @(posedge clk); #1;
                        ret_valid = 1'b0; ret_last = 1'b0; resp_flush = 1'b0;
                    end
                end
                resp_busy = 1'b0;
                beat_num  = -1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Issue n requests to the same line, back to back where the DUT allows.
    task automatic stream(input logic [11:0] idx, input logic [19:0] ptag, input logic unc,
                          input int n, input bit skip_first,
                          output int first_acc, output int last_acc);
        int acc, budget;
        bit now;
        acc = 0; budget = 0; first_acc = -1; last_acc = -1;
        inst_req = 1'b1; inst_index = idx;
        while (acc < n && budget < 200) begin
            @(negedge clk);
            now = inst_index_ok;
            if (now) begin
                if (acc == 0) first_acc = cyc;
                last_acc = cyc;
            end
            @(posedge clk); #1;
            if (now) begin
                acc++;
                inst_ptag = ptag; inst_uncached = unc;
                if (!(skip_first && acc == 1))
                    exp_q.push_back(exp_line({ptag, idx[11:4], 4'h0}, unc));
                if (acc == n) inst_req = 1'b0;
            end
            budget++;
        end
        if (acc < n) begin
            checks++; errors++;
            $display("FAIL accept_timeout: got %0d accepts, required %0d", acc, n);
            inst_req = 1'b0;
        end
    endtask

    task automatic wait_dok(input int target, input string name);
        int budget;
        budget = 0;
        while (dok_cnt < target && budget < 100) begin
            @(posedge clk); #1;
            budget++;
        end
        if (dok_cnt < target) begin
            checks++; errors++;
            $display("FAIL %s_timeout: got %0d data_ok, required %0d", name, dok_cnt, target);
        end
    endtask

    typedef struct {
        logic [11:0] idx;
        logic [19:0] ptag;
        logic        unc;
        logic        exp_refill;
    } vec_t;

    vec_t vecs[14];

    // ---------------- main test ----------------
    initial begin
        int r0, d0, fa, la, budget;
        logic [31:0] ea;

        vecs[0]  = '{12'h040, 20'hBFC00, 1'b0, 1'b1};
        vecs[1]  = '{12'h040, 20'hBFC00, 1'b0, 1'b0};
        vecs[2]  = '{12'h040, 20'h00001, 1'b0, 1'b1};
        vecs[3]  = '{12'h040, 20'hBFC00, 1'b0, 1'b1};
        vecs[4]  = '{12'h040, 20'hBFC00, 1'b1, 1'b1};
        vecs[5]  = '{12'h040, 20'hBFC00, 1'b0, 1'b0};
        vecs[6]  = '{12'h0F0, 20'h12345, 1'b0, 1'b1};
        vecs[7]  = '{12'h0F0, 20'h12345, 1'b0, 1'b0};
        vecs[8]  = '{12'h040, 20'h12345, 1'b0, 1'b1};
        vecs[9]  = '{12'hFF0, 20'hFFFFF, 1'b0, 1'b1};
        vecs[10] = '{12'h000, 20'h00000, 1'b0, 1'b1};
        vecs[11] = '{12'hFF0, 20'hFFFFF, 1'b0, 1'b0};
        vecs[12] = '{12'h000, 20'h00000, 1'b0, 1'b0};
        vecs[13] = '{12'h0F0, 20'h12345, 1'b1, 1'b1};

        rst = 1'b0; inst_req = 1'b0; inst_wr = 1'b0; inst_size = 2'b11;
        inst_index = '0; inst_wdata = '0; inst_ptag = '0; inst_uncached = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_index_ok", inst_index_ok, 0);
        chk("rst_data_ok",  inst_data_ok,  0);
        chk("rst_rdata",    inst_rdata,    0);
        chk("rst_rd_req",   rd_req,        0);
        chk("rst_rd_addr",  rd_addr,       0);
        chk("rst_rd_unc",   rd_uncached,   0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("idle_index_ok", inst_index_ok, 1);
        @(posedge clk); #1;

        // Table of single fetches
        foreach (vecs[i]) begin
            r0 = ref_cnt; d0 = dok_cnt;
            stream(vecs[i].idx, vecs[i].ptag, vecs[i].unc, 1, 1'b0, fa, la);
            wait_dok(d0 + 1, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_refills", i), ref_cnt - r0, vecs[i].exp_refill ? 1 : 0);
            if (vecs[i].exp_refill) begin
                ea = {vecs[i].ptag, vecs[i].idx[11:4], 4'h0};
                chk($sformatf("vec%0d_rd_addr", i), last_addr, ea);
                chk($sformatf("vec%0d_rd_unc", i),  last_unc,  vecs[i].unc);
            end
            if (i == 0) chk("line_040", inst_rdata, 128'h00000044_00000033_00000022_00000011);
        end

        // Back-to-back hits: one accept per cycle, no refill
        r0 = ref_cnt; d0 = dok_cnt;
        stream(12'h0F0, 20'h12345, 1'b0, 6, 1'b0, fa, la);
        wait_dok(d0 + 6, "b2b");
        chk("b2b_accept_span", la - fa, 5);
        chk("b2b_refills", ref_cnt - r0, 0);

        // Flush in LOOKUP on a hit: no data, simultaneous request ignored
        inst_req = 1'b1; inst_index = 12'h0F0;
        @(negedge clk);
        chk("lkflush_accept", inst_index_ok, 1);
        @(posedge clk); #1;
        inst_ptag = 20'h12345; inst_uncached = 1'b0; tb_flush = 1'b1; inst_index = 12'h040;
        @(negedge clk);
        chk("lkflush_index_ok", inst_index_ok, 0);
        chk("lkflush_data_ok",  inst_data_ok,  0);
        @(posedge clk); #1;
        tb_flush = 1'b0; inst_req = 1'b0;
        @(negedge clk);
        chk("lkflush_idle", inst_index_ok, 1);
        @(posedge clk); #1;

        // Flush in MISS before the refill handshake
        rdy_block = 1'b1; r0 = ref_cnt;
        stream(12'h6C0, 20'h0ABCD, 1'b0, 1, 1'b1, fa, la);
        budget = 0;
        do begin @(negedge clk); budget++; end while (!rd_req && budget < 10);
        chk("missflush_rd_req", rd_req, 1);
        chk("missflush_rd_addr", rd_addr, 32'h0ABCD6C0);
        @(posedge clk); #1;
        tb_flush = 1'b1;
        @(negedge clk);
        chk("missflush_hold", rd_req, 1);
        @(posedge clk); #1;
        tb_flush = 1'b0;
        @(negedge clk);
        chk("missflush_drop", rd_req, 0);
        chk("missflush_idle", inst_index_ok, 1);
        @(posedge clk); #1;
        rdy_block = 1'b0;
        d0 = dok_cnt;
        stream(12'h6C0, 20'h0ABCD, 1'b0, 1, 1'b0, fa, la);
        wait_dok(d0 + 1, "missflush_retry");
        chk("missflush_refills", ref_cnt - r0, 1);

        // Flush during REFILL: line installed, no data, next request in next IDLE
        flush_at_beat = 2; r0 = ref_cnt; d0 = dok_cnt;
        stream(12'h3A0, 20'hAAAAA, 1'b0, 2, 1'b1, fa, la);
        flush_at_beat = -1;
        wait_dok(d0 + 1, "rfflush");
        chk("rfflush_refills", ref_cnt - r0, 1);
        chk("rfflush_next_accept", la, last_beat_cyc + 2);
        chk("rfflush_data_oks", dok_cnt - d0, 1);

        // Reset during REFILL
        stream(12'h5A0, 20'h55555, 1'b0, 1, 1'b1, fa, la);
        budget = 0;
        do begin @(negedge clk); budget++; end while (beat_num != 1 && budget < 50);
        chk("rstrf_reach_beat1", beat_num, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rstrf_index_ok", inst_index_ok, 0);
        chk("rstrf_data_ok",  inst_data_ok,  0);
        chk("rstrf_rdata",    inst_rdata,    0);
        chk("rstrf_rd_req",   rd_req,        0);
        chk("rstrf_rd_addr",  rd_addr,       0);
        chk("rstrf_rd_unc",   rd_uncached,   0);
        @(posedge clk); #1;
        rst = 1'b1;
        budget = 0;
        while (resp_busy && budget < 50) begin @(posedge clk); #1; budget++; end
        r0 = ref_cnt; d0 = dok_cnt;
        stream(12'h000, 20'h00000, 1'b0, 1, 1'b0, fa, la);
        wait_dok(d0 + 1, "rstrf_old_hit");
        chk("rstrf_old_hit_misses", ref_cnt - r0, 1);
        chk("rstrf_old_addr", last_addr, 32'h00000000);
        r0 = ref_cnt; d0 = dok_cnt;
        stream(12'h5A0, 20'h55555, 1'b0, 1, 1'b0, fa, la);
        wait_dok(d0 + 1, "rstrf_retry");
        chk("rstrf_retry_refills", ref_cnt - r0, 1);
        chk("rstrf_retry_addr", last_addr, 32'h555555A0);

        repeat (3) @(posedge clk);
        chk("exp_q_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
